// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// One transaction at a time; bounded fetch starvation; fetch kill support.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m
);

    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t            state, state_n;
    logic [3:0]        streak, streak_n;
    logic              kill_pend, kill_pend_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              we_q, we_n;
    logic              if_live;
    logic              if_starved;

    assign if_live    = if_req & ~if_kill;
    assign if_starved = if_live & (streak == STREAK_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= '0;
            kill_pend <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
        end else begin
            state     <= state_n;
            streak    <= streak_n;
            kill_pend <= kill_pend_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            we_q      <= we_n;
        end
    end

    always_comb begin
        state_n     = state;
        streak_n    = streak;
        kill_pend_n = 1'b0;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        we_n        = we_q;
        case (state)
            IDLE: begin
                // Data side wins unless the waiting fetch has hit its streak limit
                if (dm_req && !if_starved) begin
                    state_n  = D_BUSY;
                    addr_n   = dm_addr;
                    we_n     = dm_we;
                    wdata_n  = dm_wdata;
                    if (!if_req)
                        streak_n = '0;
                    else if (streak >= STREAK_MAX)
                        streak_n = STREAK_MAX;
                    else
                        streak_n = streak + 4'd1;
                end else if (if_live) begin
                    state_n  = I_BUSY;
                    addr_n   = if_addr;
                    we_n     = 1'b0;
                    streak_n = '0;
                end
            end
            D_BUSY: begin
                if (mem_ack)
                    state_n = IDLE;
            end
            I_BUSY: begin
                // A killed fetch still runs to its ack; only its done pulse is suppressed
                kill_pend_n = ~mem_ack & (kill_pend | if_kill);
                if (mem_ack)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_valid = (state != IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign dm_done  = (state == D_BUSY) & mem_ack;
    assign dm_rdata = mem_rdata;
    assign if_done  = (state == I_BUSY) & mem_ack & ~kill_pend & ~if_kill;
    assign if_rdata = mem_rdata;

    assign stall_f = if_req & ~if_done;
    assign stall_m = dm_req & ~dm_done;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_unified_mem_arbiter;

    localparam int unsigned MAXS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_done;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_valid, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_f, stall_m;

    int tests_run = 0;
    int failed    = 0;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_f(stall_f), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = '0; if_kill = 0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1;
    endtask

    task automatic test_reset();
        pulse_reset();
        rst = 0;
        #1;
        tests_run++;
        if (mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failed++;
            $display("FAIL reset_mem got valid=%b we=%b addr=%h wdata=%h exp all 0", mem_valid, mem_we, mem_addr, mem_wdata);
        end
        tests_run++;
        if (if_done !== 1'b0 || dm_done !== 1'b0 || stall_f !== 1'b0 || stall_m !== 1'b0) begin
            failed++;
            $display("FAIL reset_flags got if_done=%b dm_done=%b stall_f=%b stall_m=%b exp 0", if_done, dm_done, stall_f, stall_m);
        end
        #3 rst = 1;
    endtask

    task automatic test_ifetch();
        step();
        if_req = 1; if_addr = 32'h10;
        #1;
        tests_run++;
        if (mem_valid !== 1'b0 || stall_f !== 1'b1) begin
            failed++;
            $display("FAIL ifetch_req_cycle got valid=%b stall_f=%b exp 0/1", mem_valid, stall_f);
        end
        step();
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || if_done !== 1'b0) begin
            failed++;
            $display("FAIL ifetch_busy1 got valid=%b addr=%h we=%b done=%b exp 1/10/0/0", mem_valid, mem_addr, mem_we, if_done);
        end
        step();
        mem_ack = 1; mem_rdata = 32'h00500093;
        #1;
        tests_run++;
        if (mem_valid !== 1'b1 || if_done !== 1'b1 || if_rdata !== 32'h00500093 || stall_f !== 1'b0) begin
            failed++;
            $display("FAIL ifetch_busy2 got valid=%b done=%b rdata=%h stall_f=%b exp 1/1/00500093/0", mem_valid, if_done, if_rdata, stall_f);
        end
        step();
        if_req = 0; mem_ack = 0;
        #1;
        tests_run++;
        if (mem_valid !== 1'b0 || if_done !== 1'b0 || stall_f !== 1'b0) begin
            failed++;
            $display("FAIL ifetch_after got valid=%b done=%b stall_f=%b exp 0/0/0", mem_valid, if_done, stall_f);
        end
    endtask

    task automatic test_store();
        step();
        dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
        step();
        mem_ack = 1;
        #1;
        tests_run++;
        if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEADBEEF) begin
            failed++;
            $display("FAIL store_bus got valid=%b we=%b addr=%h wdata=%h exp 1/1/20/deadbeef", mem_valid, mem_we, mem_addr, mem_wdata);
        end
        tests_run++;
        if (dm_done !== 1'b1 || stall_m !== 1'b0) begin
            failed++;
            $display("FAIL store_done got dm_done=%b stall_m=%b exp 1/0", dm_done, stall_m);
        end
        step();
        dm_req = 0; dm_we = 0; mem_ack = 0;
        #1;
        tests_run++;
        if (dm_done !== 1'b0 || mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL store_after got dm_done=%b valid=%b exp 0/0", dm_done, mem_valid);
        end
    endtask

    task automatic test_collision();
        step();
        if_req = 1; if_addr = 32'h30;
        dm_req = 1; dm_we = 0; dm_addr = 32'h24;
        step();
        mem_ack = 1; mem_rdata = 32'h12345678;
        #1;
        tests_run++;
        if (mem_addr !== 32'h24 || dm_done !== 1'b1 || dm_rdata !== 32'h12345678 || stall_f !== 1'b1) begin
            failed++;
            $display("FAIL collision_d_first got addr=%h dm_done=%b rdata=%h stall_f=%b exp 24/1/12345678/1", mem_addr, dm_done, dm_rdata, stall_f);
        end
        step();
        dm_req = 0; mem_ack = 0;
        #1;
        tests_run++;
        if (mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL collision_idle got valid=%b exp 0", mem_valid);
        end
        step();
        mem_ack = 1; mem_rdata = 32'h00000013;
        #1;
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h30 || if_done !== 1'b1) begin
            failed++;
            $display("FAIL collision_i_second got valid=%b addr=%h if_done=%b exp 1/30/1", mem_valid, mem_addr, if_done);
        end
        step();
        if_req = 0; mem_ack = 0;
    endtask

    task automatic test_starvation();
        logic       got [6];
        logic       exp_seq [6];
        int         n;
        exp_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        n = 0;
        step();
        if_req = 1; if_addr = 32'h100;
        dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            step();
            mem_ack = mem_valid; mem_rdata = $urandom;
            #1;
            if (mem_valid && mem_ack) begin
                got[n] = (mem_addr == 32'h200);
                n++;
            end
        end
        if_req = 0; dm_req = 0;
        step();
        mem_ack = 0;
        tests_run++;
        if (n != 6) begin
            failed++;
            $display("FAIL starvation_count got %0d grants exp 6", n);
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (got[i] !== exp_seq[i]) begin
                    failed++;
                    $display("FAIL starvation_grant%0d got is_d=%b exp is_d=%b", i, got[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_kill();
        step();
        if_req = 1; if_addr = 32'h50;
        step();
        if_kill = 1;
        #1;
        tests_run++;
        if (mem_valid !== 1'b1 || if_done !== 1'b0) begin
            failed++;
            $display("FAIL kill_busy1 got valid=%b if_done=%b exp 1/0", mem_valid, if_done);
        end
        step();
        if_kill = 0; if_addr = 32'h40;
        #1;
        tests_run++;
        if (mem_addr !== 32'h50) begin
            failed++;
            $display("FAIL kill_busy2_addr got %h exp 50", mem_addr);
        end
        step();
        mem_ack = 1; mem_rdata = 32'hAAAA5555;
        #1;
        tests_run++;
        if (if_done !== 1'b0 || stall_f !== 1'b1) begin
            failed++;
            $display("FAIL kill_ack got if_done=%b stall_f=%b exp 0/1", if_done, stall_f);
        end
        step();
        mem_ack = 0;
        #1;
        tests_run++;
        if (mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL kill_idle got valid=%b exp 0", mem_valid);
        end
        step();
        mem_ack = 1; mem_rdata = 32'h00000013;
        #1;
        tests_run++;
        if (mem_addr !== 32'h40 || if_done !== 1'b1 || if_rdata !== 32'h00000013) begin
            failed++;
            $display("FAIL kill_refetch got addr=%h if_done=%b rdata=%h exp 40/1/13", mem_addr, if_done, if_rdata);
        end
        step();
        mem_ack = 0; if_req = 1; if_kill = 1; if_addr = 32'h44;
        step();
        if_kill = 0;
        #1;
        tests_run++;
        if (mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL kill_idle_block got valid=%b exp 0", mem_valid);
        end
        step();
        mem_ack = 1;
        #1;
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h44 || if_done !== 1'b1) begin
            failed++;
            $display("FAIL kill_idle_grant got valid=%b addr=%h if_done=%b exp 1/44/1", mem_valid, mem_addr, if_done);
        end
        step();
        if_req = 0; mem_ack = 0;
    endtask

    task automatic test_reset_midop();
        step();
        if_req = 1; if_addr = 32'h70;
        dm_req = 1; dm_we = 0; dm_addr = 32'h60;
        step();
        mem_ack = 1;
        step();
        mem_ack = 0;
        step();
        #1;
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h60) begin
            failed++;
            $display("FAIL midop_busy got valid=%b addr=%h exp 1/60", mem_valid, mem_addr);
        end
        mem_ack = 1;
        #1 rst = 0;
        #1;
        tests_run++;
        if (mem_valid !== 1'b0 || dm_done !== 1'b0 || mem_addr !== 32'h0) begin
            failed++;
            $display("FAIL midop_reset got valid=%b dm_done=%b addr=%h exp 0/0/0", mem_valid, dm_done, mem_addr);
        end
        mem_ack = 0;
        #1 rst = 1;
        step();
        #1;
        // Streak was 2 before reset; a cleared streak lets the data side win again
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h60) begin
            failed++;
            $display("FAIL midop_streak_cleared got valid=%b addr=%h exp 1/60", mem_valid, mem_addr);
        end
        pulse_reset();
    endtask

    task automatic test_random();
        logic [31:0] mem_model [16];
        logic        p_if_req, p_if_kill, p_dm_req, p_dm_we, p_mv, p_ack;
        logic [31:0] p_if_addr, p_dm_addr, p_dm_wdata;
        logic        rd_i_done, rd_d_done, rd_kill;
        logic        exp_mv, exp_d, exp_ido, exp_ddo, cur_is_d, cur_we, killed;
        logic [31:0] cur_addr, cur_wdata;
        int unsigned run;

        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        pulse_reset();
        p_if_req = 0; p_if_kill = 0; p_dm_req = 0; p_dm_we = 0; p_mv = 0; p_ack = 0;
        p_if_addr = '0; p_dm_addr = '0; p_dm_wdata = '0;
        rd_i_done = 0; rd_d_done = 0; rd_kill = 0;
        cur_is_d = 0; cur_we = 0; killed = 0; cur_addr = '0; cur_wdata = '0;
        run = 0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            step();
            if (if_req) begin
                if (rd_i_done || rd_kill) begin
                    if_req  = 1'($urandom_range(0, 1));
                    if_addr = $urandom & 32'h3C;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req  = 1;
                if_addr = $urandom & 32'h3C;
            end
            if_kill = if_req && ($urandom_range(0, 7) == 0);
            if (dm_req) begin
                if (rd_d_done) begin
                    dm_req   = 1'($urandom_range(0, 1));
                    dm_we    = 1'($urandom_range(0, 1));
                    dm_addr  = $urandom & 32'h3C;
                    dm_wdata = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dm_req   = 1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = $urandom & 32'h3C;
                dm_wdata = $urandom;
            end

            exp_mv = p_mv ? !p_ack : (p_dm_req || (p_if_req && !p_if_kill));
            if (exp_mv && !p_mv) begin
                exp_d = p_dm_req && !(p_if_req && !p_if_kill && run == MAXS);
                cur_is_d  = exp_d;
                cur_addr  = exp_d ? p_dm_addr : p_if_addr;
                cur_we    = exp_d ? p_dm_we : 1'b0;
                cur_wdata = p_dm_wdata;
                killed    = 0;
                if (exp_d) run = p_if_req ? ((run < MAXS) ? run + 1 : MAXS) : 0;
                else       run = 0;
            end
            mem_ack   = exp_mv && ($urandom_range(0, 1) == 1);
            mem_rdata = mem_ack ? mem_model[cur_addr[5:2]] : $urandom;
            #1;

            exp_ddo = exp_mv && cur_is_d && mem_ack;
            exp_ido = exp_mv && !cur_is_d && mem_ack && !killed && !if_kill;

            tests_run++;
            if (mem_valid !== exp_mv) begin
                failed++;
                $display("FAIL rand_valid cyc=%0d got %b exp %b", cyc, mem_valid, exp_mv);
            end
            if (exp_mv) begin
                tests_run++;
                if (mem_addr !== cur_addr || mem_we !== cur_we || (cur_we && mem_wdata !== cur_wdata)) begin
                    failed++;
                    $display("FAIL rand_bus cyc=%0d got addr=%h we=%b wdata=%h exp addr=%h we=%b wdata=%h",
                             cyc, mem_addr, mem_we, mem_wdata, cur_addr, cur_we, cur_wdata);
                end
            end
            tests_run++;
            if (dm_done !== exp_ddo || if_done !== exp_ido) begin
                failed++;
                $display("FAIL rand_done cyc=%0d got dm=%b if=%b exp dm=%b if=%b", cyc, dm_done, if_done, exp_ddo, exp_ido);
            end
            tests_run++;
            if (stall_f !== (if_req && !exp_ido) || stall_m !== (dm_req && !exp_ddo)) begin
                failed++;
                $display("FAIL rand_stall cyc=%0d got f=%b m=%b exp f=%b m=%b", cyc, stall_f, stall_m,
                         if_req && !exp_ido, dm_req && !exp_ddo);
            end
            if (exp_ddo && !cur_we) begin
                tests_run++;
                if (dm_rdata !== mem_model[cur_addr[5:2]]) begin
                    failed++;
                    $display("FAIL rand_load cyc=%0d got %h exp %h", cyc, dm_rdata, mem_model[cur_addr[5:2]]);
                end
            end
            if (exp_ido) begin
                tests_run++;
                if (if_rdata !== mem_model[cur_addr[5:2]]) begin
                    failed++;
                    $display("FAIL rand_fetch cyc=%0d got %h exp %h", cyc, if_rdata, mem_model[cur_addr[5:2]]);
                end
            end

            if (exp_mv && mem_ack && cur_we) mem_model[cur_addr[5:2]] = cur_wdata;
            if (exp_mv && !cur_is_d && if_kill) killed = 1;
            p_if_req = if_req; p_if_kill = if_kill; p_if_addr = if_addr;
            p_dm_req = dm_req; p_dm_we = dm_we; p_dm_addr = dm_addr; p_dm_wdata = dm_wdata;
            p_mv = exp_mv; p_ack = mem_ack;
            rd_i_done = exp_ido; rd_d_done = exp_ddo; rd_kill = if_kill;
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_ifetch();
        test_store();
        test_collision();
        test_starvation();
        test_kill();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
